// File: rtl/hamming_uart_rx_if.sv
// Bundle of the serial input and the decoded-payload outputs of hamming_uart_rx.
// The slave modport is the receiver; the master modport is whoever drives the line and watches results.
interface hamming_uart_rx_if #(
    parameter int K = 4,
    parameter int C = 3
);
    logic         data_in;
    logic [K-1:0] data_out;
    logic         data_valid;
    logic         corrected;
    logic [C-1:0] syndrome;
    logic         frame_err;
    logic         busy;

    modport master (
        output data_in,
        input  data_out, data_valid, corrected, syndrome, frame_err, busy
    );

    modport slave (
        input  data_in,
        output data_out, data_valid, corrected, syndrome, frame_err, busy
    );
endinterface

// File: rtl/hamming_uart_rx.sv
// UART-style deframer for one 7-bit Hamming(7,4) codeword, with single-error correction
// and a registered one-cycle valid strobe carrying the 4-bit payload.
module hamming_uart_rx #(
    parameter int N            = 7,
    parameter int K            = 4,
    parameter int C            = 3,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    hamming_uart_rx_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(N - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DECODE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [N-1:0]     cw_q, cw_d;
    logic [K-1:0]     dataOut_q, dataOut_d;
    logic [C-1:0]     syndrome_q, syndrome_d;
    logic             corrected_q, corrected_d;
    logic             dataValid_q, dataValid_d;
    logic             frameErr_q, frameErr_d;
    logic             sync1_q, sync2_q, linePrev_q;

    logic             line;
    logic             fallEdge;
    logic [C-1:0]     syn;
    logic [N-1:0]     fixed;

    assign line     = sync2_q;
    assign fallEdge = linePrev_q & ~line;

    // Idle level is high, so the synchronizer and edge history preset to 1 to avoid a phantom start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            linePrev_q <= 1'b1;
        end else begin
            sync1_q    <= bus.data_in;
            sync2_q    <= sync1_q;
            linePrev_q <= sync2_q;
        end
    end

    always_comb begin
        syn   = {cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6],
                 cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6],
                 cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6]};
        fixed = cw_q;
        if (syn != '0) begin
            fixed[syn - 3'd1] = ~cw_q[syn - 3'd1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= '0;
            cw_q        <= '0;
            dataOut_q   <= '0;
            syndrome_q  <= '0;
            corrected_q <= 1'b0;
            dataValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitIdx_q    <= bitIdx_d;
            cw_q        <= cw_d;
            dataOut_q   <= dataOut_d;
            syndrome_q  <= syndrome_d;
            corrected_q <= corrected_d;
            dataValid_q <= dataValid_d;
            frameErr_q  <= frameErr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitIdx_d    = bitIdx_q;
        cw_d        = cw_q;
        dataOut_d   = dataOut_q;
        syndrome_d  = syndrome_q;
        corrected_d = corrected_q;
        dataValid_d = 1'b0;
        frameErr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                bitIdx_d = '0;
                if (fallEdge) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = line ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d          = '0;
                    cw_d[bitIdx_q] = line;
                    bitIdx_d       = bitIdx_q + 3'd1;
                    if (bitIdx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (line) begin
                        state_d = DECODE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                // Double errors miscorrect here by design; this code cannot detect them.
                dataOut_d   = {fixed[6], fixed[5], fixed[4], fixed[2]};
                syndrome_d  = syn;
                corrected_d = (syn != '0);
                dataValid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_out   = dataOut_q;
    assign bus.syndrome   = syndrome_q;
    assign bus.corrected  = corrected_q;
    assign bus.data_valid = dataValid_q;
    assign bus.frame_err  = frameErr_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_hamming_uart_rx.sv
// Bench for hamming_uart_rx: drives serial frames and compares each decoded strobe
// against a nearest-codeword reference model.
module tb_hamming_uart_rx;
    localparam int CPB = 16;

    logic clk;
    logic rst_n;
    hamming_uart_rx_if bus ();

    hamming_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] rxQ[$];
    int ferrCount = 0;
    int overlapCount = 0;

    // Every valid strobe is logged as {data, syndrome, corrected}; frame errors are just counted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.data_valid) rxQ.push_back({bus.data_out, bus.syndrome, bus.corrected});
            if (bus.frame_err) ferrCount++;
            if (bus.data_valid && bus.frame_err) overlapCount++;
        end
    end

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    function automatic logic [3:0] nearestPayload(input logic [6:0] cw);
        int best = 99;
        logic [3:0] bestP = '0;
        for (int p = 0; p < 16; p++) begin
            if ($countones(encode(4'(p)) ^ cw) < best) begin
                best  = $countones(encode(4'(p)) ^ cw);
                bestP = 4'(p);
            end
        end
        return bestP;
    endfunction

    task automatic applyStimulus(input logic [6:0] cw, input logic stopBit);
        bus.data_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            bus.data_in = cw[i];
            repeat (CPB) @(negedge clk);
        end
        bus.data_in = stopBit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.data_in = i[0];
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_busy got %b expected 0", bus.busy);
            end
        end
        checks++;
        if (bus.data_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_data_out got %h expected 0", bus.data_out); end
        checks++;
        if (bus.data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_valid got %b expected 0", bus.data_valid); end
        checks++;
        if (bus.corrected !== 1'b0) begin errors++; $display("[TB] FAIL reset_corrected got %b expected 0", bus.corrected); end
        checks++;
        if (bus.syndrome !== 3'h0) begin errors++; $display("[TB] FAIL reset_syndrome got %h expected 0", bus.syndrome); end
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err got %b expected 0", bus.frame_err); end
        bus.data_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] ent;
        rxQ.delete();
        ferrCount = 0;
        bus.data_in = 1'b0;
        repeat (CPB) @(negedge clk);
        bus.data_in = 1'b1;
        repeat (CPB + 4) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before got %b expected 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy_after got %b expected 0", bus.busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10 * CPB) @(negedge clk);
        checks++;
        if (rxQ.size() != 0 || ferrCount != 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_strobe got valid=%0d ferr=%0d expected 0/0", rxQ.size(), ferrCount);
        end
        applyStimulus(encode(4'b0011), 1'b1);
        repeat (4) @(negedge clk);
        ent = (rxQ.size() == 1) ? rxQ[0] : 8'hFF;
        checks++;
        if (ent !== {4'b0011, 3'b000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_resume got %h expected %h", ent, {4'b0011, 3'b000, 1'b0});
        end
    endtask

    task automatic test_clean();
        logic [7:0] ent;
        rxQ.delete();
        applyStimulus(7'b1010101, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (rxQ.size() != 1) begin errors++; $display("[TB] FAIL clean_count got %0d expected 1", rxQ.size()); end
        ent = (rxQ.size() > 0) ? rxQ[0] : 8'hFF;
        checks++;
        if (ent[7:4] !== 4'b1011) begin errors++; $display("[TB] FAIL clean_data got %b expected 1011", ent[7:4]); end
        checks++;
        if (ent[3:1] !== 3'b000) begin errors++; $display("[TB] FAIL clean_syndrome got %b expected 000", ent[3:1]); end
        checks++;
        if (ent[0] !== 1'b0) begin errors++; $display("[TB] FAIL clean_corrected got %b expected 0", ent[0]); end
    endtask

    task automatic test_single_error();
        logic [7:0] ent;
        logic [6:0] cw;
        for (int pos = 0; pos < 7; pos++) begin
            rxQ.delete();
            cw = 7'b1010101;
            cw[pos] = ~cw[pos];
            applyStimulus(cw, 1'b1);
            repeat (4) @(negedge clk);
            ent = (rxQ.size() == 1) ? rxQ[0] : 8'hFF;
            checks++;
            if (ent !== {4'b1011, 3'(pos + 1), 1'b1}) begin
                errors++;
                $display("[TB] FAIL single_err pos=%0d got %h expected %h", pos, ent, {4'b1011, 3'(pos + 1), 1'b1});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ent;
        logic [7:0] exp;
        logic [6:0] cw;
        logic [3:0] p;
        int pos;
        for (int n = 0; n < 12; n++) begin
            rxQ.delete();
            p   = 4'($urandom_range(15));
            pos = int'($urandom_range(7));
            cw  = encode(p);
            if (pos < 7) cw[pos] = ~cw[pos];
            exp = {nearestPayload(cw), (pos < 7) ? 3'(pos + 1) : 3'd0, pos < 7};
            applyStimulus(cw, 1'b1);
            repeat (4) @(negedge clk);
            ent = (rxQ.size() == 1) ? rxQ[0] : 8'hFF;
            checks++;
            if (ent !== exp) begin
                errors++;
                $display("[TB] FAIL random cw=%b got %h expected %h", cw, ent, exp);
            end
        end
    endtask

    task automatic test_false_start();
        rxQ.delete();
        ferrCount = 0;
        bus.data_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.data_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL false_start_busy_in got %b expected 1", bus.busy); end
        repeat (12) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL false_start_busy_out got %b expected 0", bus.busy); end
        repeat (12 * CPB) @(negedge clk);
        checks++;
        if (rxQ.size() != 0 || ferrCount != 0) begin
            errors++;
            $display("[TB] FAIL false_start_strobe got valid=%0d ferr=%0d expected 0/0", rxQ.size(), ferrCount);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] ent;
        applyStimulus(encode(4'b0110), 1'b1);
        repeat (4) @(negedge clk);
        rxQ.delete();
        ferrCount = 0;
        applyStimulus(encode(4'b1001), 1'b0);
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (ferrCount != 1) begin errors++; $display("[TB] FAIL frame_err_pulses got %0d expected 1", ferrCount); end
        checks++;
        if (rxQ.size() != 0) begin errors++; $display("[TB] FAIL frame_err_valid got %0d expected 0", rxQ.size()); end
        checks++;
        if (bus.data_out !== 4'b0110) begin errors++; $display("[TB] FAIL frame_err_hold got %b expected 0110", bus.data_out); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL frame_err_low_idle got %b expected 0", bus.busy); end
        bus.data_in = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(encode(4'b1001), 1'b1);
        repeat (4) @(negedge clk);
        ent = (rxQ.size() == 1) ? rxQ[0] : 8'hFF;
        checks++;
        if (ent !== {4'b1001, 3'b000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL frame_err_recover got %h expected %h", ent, {4'b1001, 3'b000, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ent;
        rxQ.delete();
        for (int p = 0; p < 16; p++) applyStimulus(encode(4'(p)), 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (rxQ.size() != 16) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 16", rxQ.size()); end
        for (int p = 0; p < 16; p++) begin
            ent = (p < rxQ.size()) ? rxQ[p] : 8'hFF;
            checks++;
            if (ent !== {4'(p), 3'b000, 1'b0}) begin
                errors++;
                $display("[TB] FAIL b2b_frame%0d got %h expected %h", p, ent, {4'(p), 3'b000, 1'b0});
            end
        end
        checks++;
        if (overlapCount != 0) begin errors++; $display("[TB] FAIL strobe_overlap got %0d expected 0", overlapCount); end
    endtask

    initial begin
        bus.data_in = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean();
        test_single_error();
        test_random();
        test_false_start();
        test_frame_error();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming_uart_rx.md
Name: hamming_uart_rx

Overview:
Serial receiver and Hamming(7,4) single-error-correcting decoder. It is the far end of the encoder/serial transmitter link. It deframes one UART-style frame carrying a 7-bit codeword, computes the 3-bit syndrome, corrects any single-bit error, and presents the 4-bit payload with a one-cycle valid strobe. It sits between the serial link wire and the 4-bit data sink (LEDs or loopback checker).

Parameters:
N, 7, codeword width in bits (fixed at 7 for this revision)
K, 4, payload width in bits
C, 3, syndrome width in bits (N-K)
CLKS_PER_BIT, 16, clk cycles per serial bit; even and >= 4

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  1  serial line; idles high
data_out  output  K  corrected payload {d4,d3,d2,d1}; holds last value
data_valid  output  1  one-cycle strobe; data_out is new this cycle
corrected  output  1  qualified by data_valid; a single-bit error was fixed
syndrome  output  C  qualified by data_valid; raw syndrome of the received word
frame_err  output  1  one-cycle strobe; stop bit sampled low, frame discarded
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all counters 0. data_out=0, data_valid=0, corrected=0, syndrome=0, frame_err=0, busy=0. Synchronizer flops are preset to 1. Reset mid-frame aborts the frame with no strobes.
- data_in passes through a 2-FF synchronizer. All references to "line" below mean the synchronized value.
- Frame format: start bit 0, then cw[0]..cw[6] (LSB first), then stop bit 1. Each bit lasts CLKS_PER_BIT cycles.
- Codeword map (index i = Hamming position i+1): cw0=p1, cw1=p2, cw2=d1, cw3=p3, cw4=d2, cw5=d3, cw6=d4.
- Syndrome:
  - s1 = cw0^cw2^cw4^cw6
  - s2 = cw1^cw2^cw5^cw6
  - s3 = cw3^cw4^cw5^cw6
  - syndrome = {s3,s2,s1}
  - If syndrome != 0, flip cw[syndrome-1].
  - data_out = {cw6,cw5,cw4,cw2} after correction.
  - Double errors are not detected; they miscorrect by design.
- FSM:
  - IDLE: wait for a falling edge on line (previous=1, current=0). Then clear the bit counter and go to START. A line held low after a frame does not retrigger.
  - START: count CLKS_PER_BIT/2 cycles to reach mid-bit, then sample. If line=1, it is a false start: return to IDLE with no strobe. If line=0, reset the counter and go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample line into cw[bit_idx] and increment bit_idx. After cw[6] is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample line. If 1, go to DECODE. If 0, pulse frame_err for one cycle, leave data_out unchanged, and go to IDLE.
  - DECODE: single cycle. Registers data_out, syndrome, and corrected=(syndrome!=0), and asserts data_valid, all valid on the next cycle. Then go to IDLE.
- Latency: data_valid is high exactly one cycle, 2 cycles after the stop-bit sample cycle.
- Back-to-back frames: a start edge immediately following the stop mid-sample is accepted. IDLE is re-entered before the next falling edge can reach the synchronizer output.
- frame_err and data_valid are never high in the same cycle.

Test Plan:
- Reset: hold rst_n=0 with data_in toggling -> all outputs 0, busy=0. Assert rst_n=0 mid-DATA -> busy=0 within 1 cycle, no data_valid follows.
- Clean frame, payload 4'b1011, cw=7'b1010101 -> one data_valid pulse with data_out=4'b1011, syndrome=3'b000, corrected=0.
- Single error: cw[4] flipped (send 7'b1000101) -> data_out=4'b1011, syndrome=3'b101, corrected=1. Repeat for each of the 7 positions, with syndromes 1..7, all yielding 4'b1011.
- False start: 3-cycle low glitch on data_in -> no data_valid, no frame_err, return to IDLE (busy low) after the mid-start sample.
- Framing error: valid start and data, stop bit driven 0 -> frame_err pulses 1 cycle, data_valid stays 0, data_out keeps its previous value. The line held low afterwards causes no new frame until high then low.
- Back-to-back frames: all 16 payloads encoded and sent with no idle gap, CLKS_PER_BIT=16 -> 16 data_valid pulses in order with matching data_out, corrected=0 throughout.
